// File: rtl/trng_pool.sv
// trng_pool: multi-channel true random number generator with output FIFO.
// CHANNELS entropy sources are sampled and whitened per channel by a
// rule-90/150 cellular automaton. The channels are XOR-combined and decimated,
// then buffered in a FIFO with a valid/ready read port. A startup warm-up and
// a repetition-count health test with a sticky failure flag gate the output.
//
// Ports:
//   clk          sole clock
//   rst_n        asynchronous active-low reset
//   en           run enable for sources, conditioners and counters
//   tst_stuck    test hook that freezes every raw sample register
//   clear_fail   pulse that clears health_fail and restarts warm-up
//   rd_ready     consumer accepts rd_data
//   rd_valid     FIFO holds a word (registered)
//   rd_data      FIFO head word, read combinationally from storage
//   health_fail  sticky repetition-count failure (registered)
//   level        FIFO occupancy (registered)
module trng_pool #(
    parameter int unsigned      WIDTH      = 8,
    parameter int unsigned      CHANNELS   = 4,
    parameter int unsigned      FIFO_DEPTH = 8,
    parameter int unsigned      WARMUP     = 16,
    parameter int unsigned      DECIM      = 4,
    parameter int unsigned      RCT_CUTOFF = 32,
    parameter logic [WIDTH-1:0] CA_MASK    = 8'h96,
    parameter int unsigned      SIM_MODEL  = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          tst_stuck,
    input  logic                          clear_fail,
    input  logic                          rd_ready,
    output logic                          rd_valid,
    output logic [WIDTH-1:0]              rd_data,
    output logic                          health_fail,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned LW  = AW + 1;
    localparam int unsigned WCW = $clog2(WARMUP + 1);
    localparam int unsigned DCW = $clog2(DECIM + 1);
    localparam int unsigned RCW = $clog2(RCT_CUTOFF + 1);

    logic [WIDTH-1:0] raw  [CHANNELS];
    logic [WIDTH-1:0] b_q  [CHANNELS];
    logic [WIDTH-1:0] d_q  [CHANNELS];
    logic [WIDTH-1:0] w_c;
    logic [WIDTH-1:0] rw_c;
    logic [WIDTH-1:0] prev_rw_q;

    logic [WCW-1:0]   wcnt_q;
    logic [DCW-1:0]   dcnt_q;
    logic [RCW-1:0]   rcnt_q;
    logic [RCW-1:0]   rcnt_nxt_c;

    logic             warm_done_c;
    logic             dec_hit_c;
    logic             trip_c;
    logic             fail_nxt_c;
    logic             push_c;
    logic             pop_c;
    logic             wr_c;

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [LW-1:0]    count_q;
    logic [LW-1:0]    count_nxt_c;

    // One conditioner step without the injected sample.
    function automatic logic [WIDTH-1:0] ca_step(input logic [WIDTH-1:0] x);
        return (x & CA_MASK) ^ (x << 1) ^ (x >> 1);
    endfunction

    // Entropy sources: ring-style loops in silicon, counters for simulation.
    generate
        if (SIM_MODEL != 0) begin : g_sim
            for (genvar k = 0; k < int'(CHANNELS); k++) begin : g_ch
                logic [WIDTH-1:0] cnt_q;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        cnt_q <= WIDTH'(k + 1);
                    end else if (en) begin
                        cnt_q <= cnt_q + WIDTH'(2 * k + 1);
                    end
                end
                assign raw[k] = cnt_q;
            end
        end else begin : g_osc
            for (genvar k = 0; k < int'(CHANNELS); k++) begin : g_ch
                logic [WIDTH-1:0] osc;
                // Free-running XOR-rotate loop, parked at zero while disabled.
                assign osc = en ? ({osc[WIDTH-2:0], osc[WIDTH-1]} ^ osc ^
                                   {osc[0], osc[WIDTH-1:1]} ^
                                   {1'b1, {(WIDTH-1){1'b0}}})
                                : '0;
                assign raw[k] = osc;
            end
        end
    endgenerate

    // Sample registers and per-channel conditioners.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(CHANNELS); k++) begin
                b_q[k] <= '0;
                d_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(CHANNELS); k++) begin
                if (!tst_stuck) begin
                    b_q[k] <= raw[k];
                end
                if (en) begin
                    d_q[k] <= ca_step(d_q[k]) ^ b_q[k];
                end
            end
        end
    end

    // Channel combine: whitened output word and raw word for the health test.
    always_comb begin
        w_c  = '0;
        rw_c = '0;
        for (int k = 0; k < int'(CHANNELS); k++) begin
            w_c  = w_c ^ d_q[k];
            rw_c = rw_c ^ b_q[k];
        end
    end

    // Repetition count: saturating run length of identical raw words.
    always_comb begin
        rcnt_nxt_c = RCW'(1);
        if (rw_c == prev_rw_q) begin
            rcnt_nxt_c = (rcnt_q == RCW'(RCT_CUTOFF)) ? rcnt_q : rcnt_q + RCW'(1);
        end
    end

    // Trip has priority over a coincident clear_fail.
    always_comb begin
        warm_done_c = (wcnt_q == WCW'(WARMUP));
        dec_hit_c   = (dcnt_q == DCW'(DECIM - 1));
        trip_c      = en && (rcnt_nxt_c == RCW'(RCT_CUTOFF));
        fail_nxt_c  = trip_c || (health_fail && !clear_fail);
        push_c      = en && warm_done_c && dec_hit_c && !health_fail &&
                      !trip_c && !clear_fail;
        pop_c       = rd_valid && rd_ready;
        // A full FIFO accepts a push only when the head leaves on the same edge.
        wr_c        = push_c && ((count_q != LW'(FIFO_DEPTH)) || pop_c);
    end

    always_comb begin
        count_nxt_c = count_q;
        if (trip_c) begin
            count_nxt_c = '0;
        end else begin
            case ({wr_c, pop_c})
                2'b10:   count_nxt_c = count_q + LW'(1);
                2'b01:   count_nxt_c = count_q - LW'(1);
                default: count_nxt_c = count_q;
            endcase
        end
    end

    // Warm-up, decimation and health counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q      <= '0;
            dcnt_q      <= '0;
            rcnt_q      <= '0;
            prev_rw_q   <= '0;
            health_fail <= 1'b0;
        end else begin
            if (clear_fail) begin
                wcnt_q <= '0;
                dcnt_q <= '0;
                rcnt_q <= '0;
            end else if (en) begin
                if (!warm_done_c) begin
                    wcnt_q <= wcnt_q + WCW'(1);
                end
                if (warm_done_c && !health_fail) begin
                    dcnt_q <= dec_hit_c ? '0 : dcnt_q + DCW'(1);
                end
                rcnt_q <= rcnt_nxt_c;
            end
            if (en) begin
                prev_rw_q <= rw_c;
            end
            health_fail <= fail_nxt_c;
        end
    end

    // Output FIFO; a health trip flushes it on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (trip_c) begin
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                if (wr_c) begin
                    mem_q[wptr_q] <= w_c;
                    wptr_q        <= wptr_q + AW'(1);
                end
                if (pop_c) begin
                    rptr_q <= rptr_q + AW'(1);
                end
            end
            count_q  <= count_nxt_c;
            rd_valid <= (count_nxt_c != '0) && !fail_nxt_c;
        end
    end

    assign rd_data = mem_q[rptr_q];
    assign level   = count_q;

endmodule

// File: tb/tb_trng_pool.sv
module tb_trng_pool;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       tst_stuck;
    logic       clear_fail;
    logic       rd_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       health_fail;
    logic [3:0] level;

    int errors = 0;
    int checks = 0;
    int n_pops = 0;

    // Reference model state
    logic [7:0] m_raw [4];
    logic [7:0] m_b   [4];
    logic [7:0] m_d   [4];
    logic [7:0] m_prev;
    int         m_wcnt;
    int         m_dcnt;
    int         m_rcnt;
    bit         m_fail;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    trng_pool #(
        .WIDTH(8), .CHANNELS(4), .FIFO_DEPTH(8), .WARMUP(16), .DECIM(4),
        .RCT_CUTOFF(32), .CA_MASK(8'h96), .SIM_MODEL(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .tst_stuck(tst_stuck),
        .clear_fail(clear_fail), .rd_ready(rd_ready), .rd_valid(rd_valid),
        .rd_data(rd_data), .health_fail(health_fail), .level(level)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] ca(input logic [7:0] x);
        return (x & 8'h96) ^ (x << 1) ^ (x >> 1);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_raw[k] = 8'(k + 1);
            m_b[k]   = 8'h00;
            m_d[k]   = 8'h00;
        end
        m_prev = 8'h00;
        m_wcnt = 0;
        m_dcnt = 0;
        m_rcnt = 0;
        m_fail = 1'b0;
        exp_q.delete();
    endtask

    // One clock edge: scoreboard the handshake, advance the model, check outputs.
    task automatic tick();
        logic [7:0] w, rw, e;
        int  rcn;
        bit  trip, push, warm, pop;
        w  = 8'h00;
        rw = 8'h00;
        for (int k = 0; k < 4; k++) begin
            w  = w ^ m_d[k];
            rw = rw ^ m_b[k];
        end
        pop = (rd_valid === 1'b1) && (rd_ready === 1'b1);
        if (pop) begin
            n_pops++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_empty: rd_data=%h but no word was expected", rd_data);
            end else begin
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    errors++;
                    $display("FAIL pop_data: rd_data=%h expected %h", rd_data, e);
                end
            end
        end
        rcn  = (rw == m_prev) ? ((m_rcnt >= 32) ? 32 : m_rcnt + 1) : 1;
        trip = en && (rcn == 32);
        warm = (m_wcnt == 16);
        push = en && warm && (m_dcnt == 3) && !m_fail && !trip && !clear_fail;

        @(posedge clk);
        #1;

        if (trip) exp_q.delete();
        else if (push && exp_q.size() < 8) exp_q.push_back(w);
        for (int k = 0; k < 4; k++) begin
            if (en) m_d[k] = ca(m_d[k]) ^ m_b[k];
            if (!tst_stuck) m_b[k] = m_raw[k];
            if (en) m_raw[k] = m_raw[k] + 8'(2 * k + 1);
        end
        if (clear_fail) begin
            m_wcnt = 0;
            m_dcnt = 0;
            m_rcnt = 0;
        end else if (en) begin
            if (!warm) m_wcnt++;
            if (warm && !m_fail) m_dcnt = (m_dcnt == 3) ? 0 : m_dcnt + 1;
            m_rcnt = rcn;
        end
        if (en) m_prev = rw;
        m_fail = trip ? 1'b1 : (clear_fail ? 1'b0 : m_fail);

        checks++;
        if (level !== 4'(exp_q.size())) begin
            errors++;
            $display("FAIL level_track: level=%0d expected %0d", level, exp_q.size());
        end
        checks++;
        if (rd_valid !== ((exp_q.size() != 0) && !m_fail)) begin
            errors++;
            $display("FAIL valid_track: rd_valid=%b expected %b", rd_valid,
                     (exp_q.size() != 0) && !m_fail);
        end
        checks++;
        if (health_fail !== m_fail) begin
            errors++;
            $display("FAIL fail_track: health_fail=%b expected %b", health_fail, m_fail);
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        en         = 1'b0;
        tst_stuck  = 1'b0;
        clear_fail = 1'b0;
        rd_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rd_valid); end
        checks++;
        if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", rd_data); end
        checks++;
        if (health_fail !== 1'b0) begin errors++; $display("FAIL reset_fail: got %b expected 0", health_fail); end
        checks++;
        if (level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    endtask

    task automatic test_warmup();
        en = 1'b1;
        rd_ready = 1'b0;
        repeat (19) tick();
        checks++;
        if (level !== 4'd0) begin errors++; $display("FAIL warmup_edge19: level=%0d expected 0", level); end
        tick();
        checks++;
        if (level !== 4'd1) begin errors++; $display("FAIL warmup_edge20: level=%0d expected 1", level); end
        checks++;
        if (rd_valid !== 1'b1) begin errors++; $display("FAIL warmup_valid: rd_valid=%b expected 1", rd_valid); end
    endtask

    task automatic test_fill_overflow();
        bit bad;
        repeat (28) tick();
        checks++;
        if (level !== 4'd8) begin errors++; $display("FAIL fill_edge48: level=%0d expected 8", level); end
        bad = 1'b0;
        repeat (12) begin
            tick();
            if (level !== 4'd8) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL overflow_hold: level=%0d expected 8 through edge 60", level); end
        en = 1'b0;
        rd_ready = 1'b1;
        n_pops = 0;
        repeat (10) tick();
        rd_ready = 1'b0;
        checks++;
        if (n_pops != 8) begin errors++; $display("FAIL drain_count: pops=%0d expected 8", n_pops); end
        checks++;
        if (level !== 4'd0) begin errors++; $display("FAIL drain_level: level=%0d expected 0", level); end
    endtask

    task automatic test_streaming();
        int max_lvl;
        do_reset();
        en = 1'b1;
        rd_ready = 1'b1;
        n_pops = 0;
        max_lvl = 0;
        repeat (60) begin
            tick();
            if (int'(level) > max_lvl) max_lvl = int'(level);
        end
        checks++;
        if (n_pops != 10) begin errors++; $display("FAIL stream_beats: pops=%0d expected 10", n_pops); end
        checks++;
        if (max_lvl != 1) begin errors++; $display("FAIL stream_level: max level=%0d expected 1", max_lvl); end
        rd_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        do_reset();
        en = 1'b1;
        rd_ready = 1'b0;
        repeat (51) tick();
        checks++;
        if (level !== 4'd8) begin errors++; $display("FAIL pp_full: level=%0d expected 8", level); end
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        checks++;
        if (level !== 4'd8) begin errors++; $display("FAIL pp_level: level=%0d expected 8", level); end
        checks++;
        if (exp_q.size() != 8 || rd_data !== exp_q[0]) begin
            errors++;
            $display("FAIL pp_head: rd_data=%h expected new head", rd_data);
        end
        en = 1'b0;
        rd_ready = 1'b1;
        n_pops = 0;
        repeat (9) tick();
        rd_ready = 1'b0;
        checks++;
        if (n_pops != 8) begin errors++; $display("FAIL pp_drain: pops=%0d expected 8", n_pops); end
    endtask

    task automatic test_health();
        bit found;
        do_reset();
        en = 1'b1;
        rd_ready = 1'b0;
        repeat (32) tick();
        checks++;
        if (level !== 4'd4) begin errors++; $display("FAIL health_pre: level=%0d expected 4", level); end
        tst_stuck = 1'b1;
        found = 1'b0;
        for (int i = 1; i <= 33; i++) begin
            tick();
            if (health_fail === 1'b1) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL health_trip: health_fail=%b expected 1 within 33 edges", health_fail); end
        checks++;
        if (level !== 4'd0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL health_flush: level=%0d rd_valid=%b expected 0/0", level, rd_valid);
        end
        repeat (8) tick();
        checks++;
        if (level !== 4'd0 || health_fail !== 1'b1) begin
            errors++;
            $display("FAIL health_hold: level=%0d health_fail=%b expected 0/1", level, health_fail);
        end
    endtask

    task automatic trip_again();
        bit found;
        tst_stuck = 1'b1;
        found = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (health_fail === 1'b1) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL retrip: health_fail=%b expected 1", health_fail); end
    endtask

    task automatic clear_pulse();
        tst_stuck = 1'b0;
        repeat (2) tick();
        clear_fail = 1'b1;
        tick();
        clear_fail = 1'b0;
        checks++;
        if (health_fail !== 1'b0) begin errors++; $display("FAIL clear: health_fail=%b expected 0", health_fail); end
    endtask

    task automatic test_recovery();
        int n;
        clear_pulse();
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (rd_valid === 1'b1) begin n = i; break; end
        end
        checks++;
        if (n != 20) begin errors++; $display("FAIL recover_latency: first push after %0d edges expected 20", n); end

        trip_again();
        clear_pulse();
        repeat (5) tick();
        en = 1'b0;
        repeat (10) tick();
        en = 1'b1;
        n = 0;
        for (int i = 16; i <= 60; i++) begin
            tick();
            if (rd_valid === 1'b1) begin n = i; break; end
        end
        checks++;
        if (n != 30) begin errors++; $display("FAIL en_gating: first push after %0d edges expected 30", n); end
    endtask

    task automatic test_async_reset();
        repeat (10) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (level !== 4'd0 || rd_valid !== 1'b0 || rd_data !== 8'h00 || health_fail !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: level=%0d rd_valid=%b rd_data=%h health_fail=%b expected all 0",
                     level, rd_valid, rd_data, health_fail);
        end
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        repeat (20) tick();
        checks++;
        if (level !== 4'd1) begin errors++; $display("FAIL restart: level=%0d expected 1 after 20 edges", level); end
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_fill_overflow();
        test_streaming();
        test_full_push_pop();
        test_health();
        test_recovery();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
